// File: rtl/noise_pkg.sv
// noise_pkg: FSM state codes, gain/divider constants and the saturation helper for lfsr_noise_shaper
package noise_pkg;
    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_STEP = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_FILT = 3'd3;
    localparam logic [2:0] S_GAIN = 3'd4;
    localparam logic [2:0] S_PUSH = 3'd5;
    localparam int GAIN_FRAC = 4;
    localparam int MIN_DIV = 5;
    function automatic logic signed [31:0] saturate(input logic signed [47:0] v, input int w);
        logic signed [47:0] hi, lo;
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (w - 1));
        return v > hi ? hi[31:0] : (v < lo ? lo[31:0] : v[31:0]);
    endfunction
endpackage

// File: rtl/lfsr_noise_shaper_if.sv
// lfsr_noise_shaper_if: valid/ready sample stream toward the DAC/PWM sink
interface lfsr_noise_shaper_if #(parameter int OUT_W = 16);
    logic [OUT_W-1:0] out_data;
    logic out_valid;
    logic out_ready;
    modport master (output out_data, out_valid, input out_ready);
    modport slave (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/noise_out_fifo.sv
// noise_out_fifo: synchronous FIFO with simultaneous push/pop at any fill level
module noise_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    assign empty = wr_q == rd_q;
    assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot a full queue would otherwise refuse
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/lfsr_noise_shaper.sv
// lfsr_noise_shaper: paces the LFSR, shapes each state into a gained signed sample and queues it.
// Define NOISE_SHAPER_IIR_EN to insert the one-pole IIR low-pass; otherwise S_FILT passes x through.
module lfsr_noise_shaper
    import noise_pkg::*;
#(
    parameter int IN_W = 24,
    parameter int OUT_W = 16,
    parameter int DIV_W = 16,
    parameter int LOCK_CNT = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  cfg_dir,
    input  logic [3:0]            cfg_alpha,
    input  logic [7:0]            cfg_gain,
    input  logic [IN_W-1:0]       lfsr_count,
    output logic                  lfsr_en,
    output logic                  lfsr_dir,
    lfsr_noise_shaper_if.master   out_if,
    output logic                  lockup,
    output logic [7:0]            drop_cnt
);
    localparam int ZW = $clog2(LOCK_CNT + 1);
    localparam int PW = OUT_W + 9;
    localparam int AW = OUT_W + 16;
    localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);
    logic [2:0] state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, lim;
    logic tick, zero, push, pop, full, empty;
    logic [7:0] gain_q, drop_q, drop_d;
    logic dir_q, lock_q, lock_d;
    logic [ZW-1:0] zrun_q, zrun_d;
    logic signed [OUT_W-1:0] x_q, y_q, s_q, y_d;
    logic signed [PW-1:0] prod;
    always_comb begin
        // clamping keeps the period at least as long as one pass through the pipeline
        lim = cfg_div < MIN_D ? MIN_D : cfg_div;
        tick = en && div_q >= lim;
        div_d = (!en || tick) ? '0 : div_q + 1'b1;
        state_d = state_q == S_WAIT ? (tick ? S_STEP : S_WAIT) :
                  state_q == S_PUSH ? S_WAIT : state_q + 3'd1;
        zero = lfsr_count == '0;
        zrun_d = !zero ? '0 : (zrun_q == ZW'(LOCK_CNT) ? zrun_q : zrun_q + 1'b1);
        lock_d = lock_q || (zero && zrun_q >= ZW'(LOCK_CNT - 1));
        pop = out_if.out_valid && out_if.out_ready;
        push = state_q == S_PUSH;
        drop_d = (push && full && !pop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
        prod = PW'(y_q) * PW'($signed({1'b0, gain_q}));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            div_q <= '0;
            gain_q <= '0;
            dir_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            s_q <= '0;
            zrun_q <= '0;
            lock_q <= 1'b0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            drop_q <= drop_d;
            if (state_q == S_STEP) begin
                gain_q <= cfg_gain;
                dir_q <= cfg_dir;
            end
            if (state_q == S_CAPT) begin
                x_q <= {~lfsr_count[IN_W-1], lfsr_count[IN_W-2:IN_W-OUT_W]};
                zrun_q <= zrun_d;
                lock_q <= lock_d;
            end
            if (state_q == S_FILT) y_q <= y_d;
            if (state_q == S_GAIN) s_q <= OUT_W'(saturate(48'(prod >>> GAIN_FRAC), OUT_W));
        end
    end
`ifdef NOISE_SHAPER_IIR_EN
    logic [3:0] alpha_q;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW:0] diff;
    always_comb begin
        diff = {x_q[OUT_W-1], x_q, 16'b0} - {acc_q[AW-1], acc_q};
        acc_d = acc_q + AW'(diff >>> alpha_q);
        y_d = acc_d[AW-1:16];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alpha_q <= '0;
            acc_q <= '0;
        end else begin
            if (state_q == S_STEP) alpha_q <= cfg_alpha;
            if (state_q == S_FILT) acc_q <= acc_d;
        end
    end
`else
    logic unused_alpha;
    assign unused_alpha = ^cfg_alpha;
    assign y_d = x_q;
`endif
    noise_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OUT_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(s_q),
        .dout(out_if.out_data),
        .full(full),
        .empty(empty)
    );
    assign out_if.out_valid = !empty;
    assign lfsr_en = state_q == S_STEP;
    assign lfsr_dir = dir_q;
    assign lockup = lock_q;
    assign drop_cnt = drop_q;
endmodule
